// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: forwarding selects, load-use stall, taken-branch flush, multi-cycle EX stall.
// Outputs are combinational from the current state and inputs, and are forced low while rst_n is asserted.
module hazard_ctrl_unit #(
    parameter int AW       = 6,
    parameter int NUM_SRC  = 2,
    parameter int MC_LAT   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC*AW-1:0] src_id,
    input  logic [NUM_SRC*AW-1:0] src_ex,
    input  logic [AW-1:0]         rf_ex,
    input  logic                  we_ex,
    input  logic                  mem_rd_ex,
    input  logic                  mc_start_ex,
    input  logic                  branch_taken_ex,
    input  logic [AW-1:0]         rf_me,
    input  logic                  we_me,
    input  logic [AW-1:0]         rf_wb,
    input  logic                  we_wb,
    output logic [2*NUM_SRC-1:0]  fwd_sel,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  stall_idex,
    output logic                  bubble_ex,
    output logic                  bubble_me,
    output logic                  flush_ifid,
    output logic                  mc_busy
);
    localparam int CW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam logic MC_EN = (MC_LAT > 1);

    typedef enum logic {IDLE, MC_WAIT} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;

    // A source matches a writer only if the writer is enabled and the register is not the hardwired zero.
    function automatic logic reg_hit(input logic [AW-1:0] src, input logic we, input logic [AW-1:0] dst);
        return we && (src == dst) && !((ZERO_REG != 0) && (src == '0));
    endfunction

    logic lu, mc_issue, mc_hold, mc_stall, br_act, lu_act, idle;

    always_comb begin
        fwd_sel = '0;
        lu      = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (reg_hit(src_ex[i*AW +: AW], we_me, rf_me))
                fwd_sel[2*i +: 2] = 2'b01;
            else if (reg_hit(src_ex[i*AW +: AW], we_wb, rf_wb))
                fwd_sel[2*i +: 2] = 2'b10;
            if (reg_hit(src_id[i*AW +: AW], we_ex, rf_ex))
                lu = 1'b1;
        end
        lu      = lu & mem_rd_ex;
        fwd_sel = rst_n ? fwd_sel : '0;
    end

    assign idle     = (state_q == IDLE);
    assign mc_issue = idle && mc_start_ex && MC_EN;
    assign mc_hold  = (state_q == MC_WAIT) && (cnt_q != '0);
    assign mc_stall = mc_issue || mc_hold;
    // Multi-cycle stall outranks branch, which outranks load-use; both are silent outside IDLE.
    assign br_act   = idle && !mc_issue && branch_taken_ex;
    assign lu_act   = idle && !mc_issue && !branch_taken_ex && lu;

    assign stall_pc   = rst_n && (mc_stall || lu_act);
    assign stall_ifid = rst_n && (mc_stall || lu_act);
    assign stall_idex = rst_n && mc_stall;
    assign bubble_me  = rst_n && mc_stall;
    assign bubble_ex  = rst_n && (br_act || lu_act);
    assign flush_ifid = rst_n && br_act;
    assign mc_busy    = (state_q == MC_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mc_issue) begin
                        state_q <= MC_WAIT;
                        cnt_q   <= CW'(MC_LAT - 2);
                    end
                end
                MC_WAIT: begin
                    if (cnt_q != '0)
                        cnt_q <= cnt_q - CW'(1);
                    else
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
